// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - period and high-time monitor for a slow divided clock (option: CLOCK_MONITOR_SYNC_EN)
module clock_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535   // legal range 2 .. 2**CNT_W-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;
    logic             s_src;
    logic             s;
    logic             prev;
    logic             rise;
    logic             fall;
    logic             at_timeout;

`ifdef CLOCK_MONITOR_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer for a clk_in that is asynchronous to clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= clk_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s_src = sync_q2;
`else
    // clk_in is derived from clk, so a single sampling register suffices
    assign s_src = clk_in;
`endif

    // Sample the divided clock and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= 1'b0;
            prev <= 1'b0;
        end else begin
            s    <= s_src;
            prev <= s;
        end
    end

    assign rise       = s & ~prev;
    assign fall       = ~s & prev;
    assign at_timeout = (cnt == TMO);

    // Measurement FSM: arm on the first rise, then report every rise-to-rise interval
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_tmp    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Disabling drops any measurement in progress but keeps the last result
                state <= IDLE;
                cnt   <= '0;
                stuck <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                    ARM: begin
                        busy <= 1'b1;
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            stuck <= 1'b0;
                            state <= MEASURE;
                        end else if (at_timeout) begin
                            // Restart the timeout window so cnt never wraps
                            stuck <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        busy <= 1'b1;
                        if (fall) begin
                            hi_tmp <= cnt;
                        end
                        // A rise on the timeout cycle is still a legal period
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hi_tmp;
                            valid     <= 1'b1;
                            cnt       <= CNT_W'(1);
                        end else if (at_timeout) begin
                            stuck <= 1'b1;
                            cnt   <= '0;
                            state <= ARM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - directed-vector bench for clock_monitor
module tb_clock_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clk_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        stuck;
    logic        busy;

    int n_vec;
    int n_err;

    // Divider model driving clk_in just after each clk edge
    logic div_run;
    int   div_lo;
    int   div_hi;
    int   ph;

    clock_monitor #(
        .CNT_W  (16),
        .TIMEOUT(20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clk_in   (clk_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .stuck    (stuck),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        clk_in = 1'b0;
        ph     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!div_run) begin
                clk_in = 1'b0;
                ph     = 0;
            end else begin
                ph = ph + 1;
                if (!clk_in && ph >= div_lo) begin
                    clk_in = 1'b1;
                    ph     = 0;
                end else if (clk_in && ph >= div_hi) begin
                    clk_in = 1'b0;
                    ph     = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max, output bit found, output int cyc, output int rises);
        logic last;
        last  = clk_in;
        found = 1'b0;
        cyc   = 0;
        rises = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (clk_in && !last) rises++;
            last = clk_in;
            if (valid) begin
                found = 1'b1;
                cyc   = i;
                break;
            end
        end
    endtask

    initial begin
        bit found;
        int cyc;
        int rises;
        bit saw_valid;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        div_run = 1'b0;
        div_lo  = 2;
        div_hi  = 2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Divide-by-4: first valid on second rise, then every 4 cycles
        en = 1'b1;
        @(negedge clk);
        check("en_busy", 32'(busy), 1);
        div_run = 1'b1;
        wait_valid(40, found, cyc, rises);
        check("d4_found", 32'(found), 1);
        check("d4_first_rises", 32'(rises), 2);
        check("d4_period", 32'(period), 4);
        check("d4_high", 32'(high_time), 2);
        @(negedge clk);
        check("d4_pulse_len", 32'(valid), 0);
        wait_valid(40, found, cyc, rises);
        check("d4_found2", 32'(found), 1);
        check("d4_spacing", 32'(cyc + 1), 4);
        check("d4_period2", 32'(period), 4);
        check("d4_high2", 32'(high_time), 2);
        check("d4_stuck", 32'(stuck), 0);

        // Divide-by-5 (low 2, high 3)
        div_lo = 2;
        div_hi = 3;
        wait_valid(40, found, cyc, rises);
        wait_valid(40, found, cyc, rises);
        wait_valid(40, found, cyc, rises);
        check("d5_found", 32'(found), 1);
        check("d5_spacing", 32'(cyc), 5);
        check("d5_period", 32'(period), 5);
        check("d5_high", 32'(high_time), 3);

        // Drop en during the next rise-detection cycle
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drop_valid", 32'(valid), 0);
        check("drop_busy", 32'(busy), 0);
        check("drop_stuck", 32'(stuck), 0);
        check("drop_period", 32'(period), 5);
        check("drop_high", 32'(high_time), 3);

        // Stuck low with TIMEOUT=20
        div_run = 1'b0;
        repeat (3) @(negedge clk);
        en        = 1'b1;
        saw_valid = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        check("stuck_before", 32'(stuck), 0);
        @(negedge clk);
        if (valid) saw_valid = 1'b1;
        check("stuck_set", 32'(stuck), 1);
        check("stuck_no_valid", 32'(saw_valid), 0);
        div_lo  = 2;
        div_hi  = 2;
        div_run = 1'b1;
        wait_valid(60, found, cyc, rises);
        check("recover_found", 32'(found), 1);
        check("recover_rises", 32'(rises), 2);
        check("recover_stuck", 32'(stuck), 0);
        check("recover_period", 32'(period), 4);
        check("recover_high", 32'(high_time), 2);

        // Reset mid-measurement
        div_run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_period", 32'(period), 0);
        check("mrst_high", 32'(high_time), 0);
        check("mrst_valid", 32'(valid), 0);
        check("mrst_stuck", 32'(stuck), 0);
        check("mrst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_busy_after", 32'(busy), 1);
        div_run = 1'b1;
        wait_valid(60, found, cyc, rises);
        check("mrst_found", 32'(found), 1);
        check("mrst_rises", 32'(rises), 2);
        check("mrst_period2", 32'(period), 4);
        check("mrst_high2", 32'(high_time), 2);

        // Period exactly TIMEOUT is a valid measurement, not stuck
        div_run = 1'b0;
        div_lo  = 10;
        div_hi  = 10;
        repeat (2) @(negedge clk);
        div_run = 1'b1;
        wait_valid(80, found, cyc, rises);
        check("tmo_found1", 32'(found), 1);
        wait_valid(40, found, cyc, rises);
        check("tmo_found2", 32'(found), 1);
        check("tmo_spacing", 32'(cyc), 20);
        check("tmo_period", 32'(period), 20);
        check("tmo_high", 32'(high_time), 10);
        check("tmo_stuck", 32'(stuck), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
